// File: rtl/pipeline_id_ex_pkg.sv
// Shared encodings for the ID stage: MIPS opcode/funct values, ALU function codes,
// PC source selects and the ID/EX word layout.
package pipeline_id_ex_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned IDEX_W = 164;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI   = 6'h0F,
        OP_LW    = 6'h23, OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_JR   = 6'h08,
        F_JALR = 6'h09, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
        F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
        F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [5:0] {
        ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000,
        ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001,
        ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011,
        ALU_SLT = 6'b110101
    } alu_fun_e;

    typedef enum logic [2:0] {
        PC_SEQ   = 3'd0,
        PC_JT    = 3'd2,
        PC_JR    = 3'd3,
        PC_ILLOP = 3'd4
    } pc_src_e;

    typedef struct packed {
        logic       signed_op;
        logic       branch_ne;
        logic       branch;
        alu_fun_e   alu_fun;
        logic       alu_src_b;
        logic       alu_src_a;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_addr;
        ctrl_t       ctrl;
    } idex_t;

endpackage

// File: rtl/pipeline_id_ex_regfile.sv
// 32-entry register file: two combinational read ports with write-through, one write port,
// $0 hardwired to zero, asynchronous active-low clear.
module pipeline_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0)                      rdata_a_o = '0;
        else if (wr_en && waddr_i == raddr_a_i)   rdata_a_o = wdata_i;
    end

    always_comb begin
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0)                      rdata_b_o = '0;
        else if (wr_en && waddr_i == raddr_b_i)   rdata_b_o = wdata_i;
    end

endmodule

// File: rtl/pipeline_id_ex.sv
// ID stage: decode, register read, load-use hazard detection, jump resolution,
// and the ID/EX pipeline register.
module pipeline_id_ex
    import pipeline_id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = pipeline_id_ex_pkg::DATA_W,
    parameter int unsigned NREG   = pipeline_id_ex_pkg::NREG,
    parameter int unsigned IDEX_W = pipeline_id_ex_pkg::IDEX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       IFID,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WrAddr,
    input  logic [DATA_W-1:0] WB_Data,
    input  logic              Flush,
    output logic [IDEX_W-1:0] IDEX,
    output logic              Stall,
    output logic              Nop_IF,
    output logic [2:0]        PCSrc_ID,
    output logic [25:0]       JT,
    output logic [DATA_W-1:0] DatabusA
);

    logic [31:0] instr;
    logic [4:0]  rs, rt, rd;
    logic [DATA_W-1:0] rd_a, rd_b;
    idex_t   idex_q, idex_d, dec;
    logic    legal, reads_rt, jump_imm, jump_reg, hazard;
    pc_src_e pc_src;

    assign instr = IFID[31:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    pipeline_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst_ni    (reset),
        .we_i      (WB_RegWrite),
        .waddr_i   (WB_WrAddr),
        .wdata_i   (WB_Data),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    always_comb begin
        dec         = '0;
        legal       = 1'b1;
        reads_rt    = 1'b0;
        jump_imm    = 1'b0;
        jump_reg    = 1'b0;
        dec.pc4     = IFID[63:32];
        dec.a       = rd_a;
        dec.b       = rd_b;
        dec.imm     = {{16{instr[15]}}, instr[15:0]};
        dec.shamt   = instr[10:6];
        dec.rs      = rs;
        dec.rt      = rt;
        dec.wr_addr = rt;
        case (instr[31:26])
            OP_RTYPE: begin
                dec.wr_addr        = rd;
                dec.ctrl.reg_write = 1'b1;
                reads_rt           = 1'b1;
                case (instr[5:0])
                    F_ADD:  begin dec.ctrl.alu_fun = ALU_ADD; dec.ctrl.signed_op = 1'b1; end
                    F_ADDU: dec.ctrl.alu_fun = ALU_ADD;
                    F_SUB:  begin dec.ctrl.alu_fun = ALU_SUB; dec.ctrl.signed_op = 1'b1; end
                    F_SUBU: dec.ctrl.alu_fun = ALU_SUB;
                    F_AND:  dec.ctrl.alu_fun = ALU_AND;
                    F_OR:   dec.ctrl.alu_fun = ALU_OR;
                    F_XOR:  dec.ctrl.alu_fun = ALU_XOR;
                    F_NOR:  dec.ctrl.alu_fun = ALU_NOR;
                    F_SLT:  begin dec.ctrl.alu_fun = ALU_SLT; dec.ctrl.signed_op = 1'b1; end
                    F_SLTU: dec.ctrl.alu_fun = ALU_SLT;
                    F_SLL:  begin dec.ctrl.alu_fun = ALU_SLL; dec.ctrl.alu_src_a = 1'b1; end
                    F_SRL:  begin dec.ctrl.alu_fun = ALU_SRL; dec.ctrl.alu_src_a = 1'b1; end
                    F_SRA:  begin dec.ctrl.alu_fun = ALU_SRA; dec.ctrl.alu_src_a = 1'b1; end
                    F_JR:   begin dec.ctrl.reg_write = 1'b0; jump_reg = 1'b1; reads_rt = 1'b0; end
                    F_JALR: begin dec.ctrl.mem_to_reg = 2'd2; jump_reg = 1'b1; reads_rt = 1'b0; end
                    default: legal = 1'b0;
                endcase
            end
            OP_J:   jump_imm = 1'b1;
            OP_JAL: begin
                jump_imm            = 1'b1;
                dec.wr_addr         = 5'd31;
                dec.ctrl.reg_write  = 1'b1;
                dec.ctrl.mem_to_reg = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                reads_rt           = 1'b1;
                dec.ctrl.alu_fun   = ALU_SUB;
                dec.ctrl.branch    = 1'b1;
                dec.ctrl.branch_ne = (instr[31:26] == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src_b = 1'b1;
                case (instr[31:26])
                    OP_ADDI:  begin dec.ctrl.alu_fun = ALU_ADD; dec.ctrl.signed_op = 1'b1; end
                    OP_SLTI:  begin dec.ctrl.alu_fun = ALU_SLT; dec.ctrl.signed_op = 1'b1; end
                    OP_SLTIU: dec.ctrl.alu_fun = ALU_SLT;
                    OP_ANDI:  begin dec.ctrl.alu_fun = ALU_AND; dec.imm = {16'h0, instr[15:0]}; end
                    OP_ORI:   begin dec.ctrl.alu_fun = ALU_OR;  dec.imm = {16'h0, instr[15:0]}; end
                    OP_LUI:   begin dec.ctrl.alu_fun = ALU_ADD; dec.imm = {instr[15:0], 16'h0}; end
                    default:  dec.ctrl.alu_fun = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.ctrl.reg_write  = 1'b1;
                dec.ctrl.mem_read   = 1'b1;
                dec.ctrl.mem_to_reg = 2'd1;
                dec.ctrl.alu_src_b  = 1'b1;
            end
            OP_SW: begin
                reads_rt           = 1'b1;
                dec.ctrl.mem_write = 1'b1;
                dec.ctrl.alu_src_b = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Flush outranks the hazard, which in turn defers any jump/illegal redirect.
    always_comb begin
        hazard = idex_q.ctrl.mem_read && (idex_q.wr_addr != '0) &&
                 ((idex_q.wr_addr == rs) || (reads_rt && idex_q.wr_addr == rt));
        Stall  = hazard && !Flush;
        Nop_IF = 1'b0;
        pc_src = PC_SEQ;
        if (!Flush && !hazard) begin
            if (!legal) begin
                pc_src = PC_ILLOP;
                Nop_IF = 1'b1;
            end else if (jump_imm) begin
                pc_src = PC_JT;
                Nop_IF = 1'b1;
            end else if (jump_reg) begin
                pc_src = PC_JR;
                Nop_IF = 1'b1;
            end
        end
        idex_d = (Flush || hazard || !legal) ? '0 : dec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign IDEX     = idex_q;
    assign PCSrc_ID = pc_src;
    assign JT       = instr[25:0];
    assign DatabusA = rd_a;

endmodule
